laser_pulse_sequencer: RTL
==========================

// Module: laser_pulse_sequencer
// PURPOSE
// - Multi-channel successor of the single-trigger laser synchronizer: on each mirror zero crossing it walks a
//   per-point dt-tick table (written by the dt-tick generator) and fires laser pulses at the stored offsets.
// - Sits between the dt-tick memory read port and the laser driver outputs.
// - Adds channel masking, runtime pulse length, late-point and overrun detection, optional bidirectional sweep.
// PARAMETERS
// - TICK_W    16   width of one dt-tick entry and of the elapsed counter
// - ADDR_W    11   dt-tick memory address width
// - POINTS_P  360  points per half mirror period (table entries 0..POINTS_P-1)
// - NUM_CH    4    number of laser trigger channels
// - PULSE_W   8    width of pulse_len_i
// - MEM_LAT   2    dt-tick memory read latency in cycles (>=1)
// PORTS
// - clk_i            in   1        system clock
// - rst_i            in   1        synchronous reset, active-high
// - en_i             in   1        block enable
// - zc_i             in   1        mirror zero-crossing level, synchronous to clk_i; both edges start a sweep
// - pulse_len_i      in   PULSE_W  trigger high time in cycles, sampled at sweep start; 0 treated as 1
// - ch_mask_i        in   NUM_CH   channels fired in this sweep, sampled at sweep start
// - ren_o            out  1        dt-tick memory read enable (1-cycle strobe)
// - raddr_o          out  ADDR_W   dt-tick memory read address
// - rdata_i          in   TICK_W   dt-tick read data, valid exactly MEM_LAT cycles after ren_o
// - laser_trigger_o  out  NUM_CH   laser trigger pulses (registered)
// - busy_o           out  1        sweep in progress
// - done_o           out  1        1-cycle strobe after last point of a sweep fired
// - late_o           out  1        sticky: a point fired later than its dt (dt too small for fetch latency)
// - overrun_o        out  1        sticky: zc edge arrived before sweep finished
// - clr_i            in   1        clears late_o and overrun_o (rst_i clears them too)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, zc history register loaded with zc_i (no spurious edge after reset).
// - Edge detect: edge = zc_i ^ zc_q; edge seen in cycle e -> FETCH in cycle e+1, elapsed=0 in e+1.
// - FSM: IDLE -> FETCH (ren_o=1, raddr_o=point) -> WAIT (MEM_LAT cycles; rdata_i captured into dt_q on last)
//   -> ARM (hold until elapsed>=dt_q; then fire) -> FETCH next point, or IDLE with done_o after point POINTS_P-1.
// - elapsed: TICK_W counter, +1 per cycle, saturates at all-ones, restarts on sweep start and on every fire.
// - Timing: first rising edge of laser_trigger_o at cycle e+2+dt_0; subsequent rises spaced exactly dt_n cycles
//   from the previous rise when dt_n >= MEM_LAT+2; otherwise fire at earliest ARM cycle and set late_o.
// - Fire: laser_trigger_o <= mask_q for len_q cycles; a new fire while a pulse is high restarts the length count.
// - Point order: addresses 0..POINTS_P-1 (see CONFIGURATION for falling-edge order).
// - zc edge while busy: overrun_o set, current sweep aborted, trigger dropped, new sweep starts per edge rule.
// - zc edge in same cycle as done_o: new sweep starts normally, overrun_o not set.
// - en_i low: next cycle state IDLE, laser_trigger_o 0, ren_o 0, edges ignored; zc_q still tracks zc_i.
// - rst_i mid-sweep: everything returns to reset values next cycle, no trailing pulse.
// - clr_i and a new late/overrun event in same cycle: event wins (flag stays 1).
// CONFIGURATION
// - LPS_BIDIR_EN defined: rising edge sweeps addresses 0..POINTS_P-1, falling edge sweeps POINTS_P-1..0
//   (mirror travels back; table reused reversed). Undefined: both edges sweep 0..POINTS_P-1.
// TESTING (bench: POINTS_P=4, MEM_LAT=2, NUM_CH=4)
// - Table {10,10,10,10}, mask 4'b0101, len 3, zc rise at e -> trigger 4'b0101 rises e+12, e+22, e+32, e+42,
//   each 3 cycles wide; done_o once after 4th fire; late_o=0.
// - Table {10,2,10,10} -> 2nd point fires at earliest ARM (spacing 4), late_o=1; clr_i clears it.
// - zc toggles again 20 cycles after first edge -> overrun_o=1, sweep restarts at address 0 (or 3 with
//   LPS_BIDIR_EN on falling edge), no pulse from aborted point.
// - LPS_BIDIR_EN, falling edge -> raddr_o sequence 3,2,1,0; undefined -> 0,1,2,3.
// - pulse_len_i=0 -> 1-cycle pulses; pulse_len_i=15 with dt=10 -> pulse restarts, trigger stays high continuously.
// - en_i low mid-sweep or rst_i high mid-pulse -> trigger 0 next cycle, busy_o 0, no done_o.

Source files
------------

// File: rtl/laser_pulse_sequencer.sv
// laser_pulse_sequencer: walks a dt-tick table on each mirror zero crossing, firing masked laser pulses.
// Latency: first pulse at e+2+dt_0 after edge cycle e, later pulses dt_n apart (floor MEM_LAT+2, else late_o).
// No backpressure: memory must answer exactly MEM_LAT cycles after ren_o. LPS_BIDIR_EN: falling edge sweeps reversed.
module laser_pulse_sequencer #(
  parameter int TICK_W   = 16,
  parameter int ADDR_W   = 11,
  parameter int POINTS_P = 360,
  parameter int NUM_CH   = 4,
  parameter int PULSE_W  = 8,
  parameter int MEM_LAT  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               zc_i,
  input  logic [PULSE_W-1:0] pulse_len_i,
  input  logic [NUM_CH-1:0]  ch_mask_i,
  output logic               ren_o,
  output logic [ADDR_W-1:0]  raddr_o,
  input  logic [TICK_W-1:0]  rdata_i,
  output logic [NUM_CH-1:0]  laser_trigger_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               late_o,
  output logic               overrun_o,
  input  logic               clr_i
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_ARM} state_t;

  localparam int WC_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int PC_W = (POINTS_P > 1) ? $clog2(POINTS_P) : 1;
  localparam logic [TICK_W-1:0] EL_MAX  = '1;
  localparam logic [PC_W-1:0]   PT_LAST = PC_W'(POINTS_P - 1);

  state_t              state_q, state_d;
  logic                zc_q, zc_d;
  logic                dir_q, dir_d;
  logic [PC_W-1:0]     pt_q, pt_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic [TICK_W-1:0]   dt_q, dt_d;
  logic [TICK_W-1:0]   el_q, el_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [PULSE_W-1:0]  len_q, len_d;
  logic [PULSE_W-1:0]  pcnt_q, pcnt_d;
  logic [NUM_CH-1:0]   trig_q, trig_d;
  logic                ren_q, ren_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                late_q, late_d;
  logic                ovr_q, ovr_d;

  logic                zc_edge;
  logic                start_desc;
  logic                fire;
  logic [PULSE_W-1:0]  len_eff;

  assign zc_edge = zc_i ^ zc_q;
  assign len_eff = (len_q == '0) ? PULSE_W'(1) : len_q;

  // Descending sweeps reuse the same table while the mirror travels back.
`ifdef LPS_BIDIR_EN
  assign start_desc = ~zc_i;
`else
  assign start_desc = 1'b0;
`endif

  function automatic logic [ADDR_W-1:0] pt_addr(input logic [PC_W-1:0] p, input logic desc);
    if (desc) return ADDR_W'(POINTS_P - 1) - ADDR_W'(p);
    return ADDR_W'(p);
  endfunction

  always_comb begin
    state_d = state_q;
    zc_d    = zc_i;
    dir_d   = dir_q;
    pt_d    = pt_q;
    wcnt_d  = wcnt_q;
    dt_d    = dt_q;
    el_d    = (el_q == EL_MAX) ? el_q : el_q + TICK_W'(1);
    mask_d  = mask_q;
    len_d   = len_q;
    pcnt_d  = (pcnt_q != '0) ? pcnt_q - PULSE_W'(1) : '0;
    ren_d   = 1'b0;
    raddr_d = raddr_q;
    done_d  = 1'b0;
    late_d  = late_q & ~clr_i;
    ovr_d   = ovr_q & ~clr_i;
    fire    = 1'b0;

    if (!en_i) begin
      state_d = S_IDLE;
      pcnt_d  = '0;
    end else if (zc_edge) begin
      if (state_q != S_IDLE) begin
        ovr_d  = 1'b1;
        pcnt_d = '0;
      end
      state_d = S_FETCH;
      pt_d    = '0;
      dir_d   = start_desc;
      el_d    = '0;
      mask_d  = ch_mask_i;
      len_d   = pulse_len_i;
      ren_d   = 1'b1;
      raddr_d = pt_addr('0, start_desc);
    end else begin
      unique case (state_q)
        S_FETCH: begin
          state_d = S_WAIT;
          wcnt_d  = WC_W'(MEM_LAT - 1);
        end
        S_WAIT: begin
          if (wcnt_q == '0) begin
            dt_d    = rdata_i;
            state_d = S_ARM;
          end else begin
            wcnt_d = wcnt_q - WC_W'(1);
          end
        end
        S_ARM: begin
          if (el_q >= dt_q) begin
            fire   = 1'b1;
            // The fire cycle itself is tick 0 of the next interval, so the next rise lands dt later.
            el_d   = TICK_W'(1);
            pcnt_d = len_eff;
            if (el_q > dt_q) late_d = 1'b1;
            if (pt_q == PT_LAST) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              pt_d    = pt_q + PC_W'(1);
              state_d = S_FETCH;
              ren_d   = 1'b1;
              raddr_d = pt_addr(pt_q + PC_W'(1), dir_q);
            end
          end
        end
        default: ;
      endcase
    end

    trig_d = (pcnt_d == '0) ? '0 : (fire ? mask_q : trig_q);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      zc_q    <= zc_i;
      dir_q   <= 1'b0;
      pt_q    <= '0;
      wcnt_q  <= '0;
      dt_q    <= '0;
      el_q    <= '0;
      mask_q  <= '0;
      len_q   <= '0;
      pcnt_q  <= '0;
      trig_q  <= '0;
      ren_q   <= 1'b0;
      raddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      late_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      zc_q    <= zc_d;
      dir_q   <= dir_d;
      pt_q    <= pt_d;
      wcnt_q  <= wcnt_d;
      dt_q    <= dt_d;
      el_q    <= el_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      pcnt_q  <= pcnt_d;
      trig_q  <= trig_d;
      ren_q   <= ren_d;
      raddr_q <= raddr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      late_q  <= late_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ren_o           = ren_q;
  assign raddr_o         = raddr_q;
  assign laser_trigger_o = trig_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign late_o          = late_q;
  assign overrun_o       = ovr_q;

endmodule
